// File: rtl/mv_pkg.sv
// rtl/mv_pkg.sv - shared state type, default sizes and address-width helper for mv_seq
package mv_pkg;

    localparam int DEF_M          = 4;
    localparam int DEF_N          = 4;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_BRAM_DEPTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } mv_state_e;

    // Width needed to index 0..depth-1; never less than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_AW = addr_w(DEF_BRAM_DEPTH);

endpackage

// File: rtl/mv_seq_if.sv
// rtl/mv_seq_if.sv - host/BRAM/MAC signal bundle for the matrix-vector sequencer
//
// Host side : start, hold, mat_base, vec_base, res_base -> busy, done
// BRAM side : mat_rd_en, mat_rd_addr, vec_rd_addr, res_wr_en, res_wr_addr
// MAC side  : acc_en, acc_clr
// slave modport is used by mv_seq, master modport by whoever drives it.
interface mv_seq_if
    import mv_pkg::*;
#(
    parameter int AW = DEF_AW
) ();

    logic          start;
    logic          hold;
    logic [AW-1:0] mat_base;
    logic [AW-1:0] vec_base;
    logic [AW-1:0] res_base;
    logic          busy;
    logic          done;
    logic          mat_rd_en;
    logic [AW-1:0] mat_rd_addr;
    logic [AW-1:0] vec_rd_addr;
    logic          acc_en;
    logic          acc_clr;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;

    modport master (
        output start, hold, mat_base, vec_base, res_base,
        input  busy, done, mat_rd_en, mat_rd_addr, vec_rd_addr,
        input  acc_en, acc_clr, res_wr_en, res_wr_addr
    );

    modport slave (
        input  start, hold, mat_base, vec_base, res_base,
        output busy, done, mat_rd_en, mat_rd_addr, vec_rd_addr,
        output acc_en, acc_clr, res_wr_en, res_wr_addr
    );

endinterface

// File: rtl/mv_dly.sv
// rtl/mv_dly.sv - RD_LAT-deep delay line carrying {acc_clr, acc_en} to the MAC
//
// Ports: clk, rst (async active-low); i_en/i_clr in; o_en/o_clr out after
// exactly RD_LAT cycles; o_pending flags an enable still inside the line that
// has not yet reached the output stage.
module mv_dly
    import mv_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_en,
    output logic o_clr,
    output logic o_pending
);

    // Bit 0 = enable, bit 1 = clear; stage RD_LAT-1 is the output.
    logic [RD_LAT-1:0][1:0] r_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= '0;
        end else begin
            r_line[0] <= {i_clr & i_en, i_en};
            for (int i = 1; i < RD_LAT; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_en  = r_line[RD_LAT-1][0];
    assign o_clr = r_line[RD_LAT-1][1];

    always_comb begin
        o_pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            o_pending = o_pending | r_line[i][0];
        end
    end

endmodule

// File: rtl/mv_seq.sv
// rtl/mv_seq.sv - sequencer for y = A*x: streams BRAM reads, drives the MAC, writes one result per row
//
// Ports: clk; rst (async active-low); bus (mv_seq_if.slave) carrying the host
// start/hold/base inputs, busy/done status, BRAM read/write strobes and
// addresses, and the MAC acc_en/acc_clr controls.
module mv_seq
    import mv_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int N          = DEF_N,
    parameter int BRAM_DEPTH = DEF_BRAM_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic   clk,
    input  logic   rst,
    mv_seq_if.slave bus
);

    localparam int AW = addr_w(BRAM_DEPTH);
    localparam int CW = addr_w(N);
    localparam int RW = addr_w(M);
    localparam int DW = addr_w(RD_LAT);

    mv_state_e     r_state;
    mv_state_e     w_next;
    logic [AW-1:0] r_mat_ptr;
    logic [AW-1:0] r_vec_base;
    logic [AW-1:0] r_res_base;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DW-1:0] r_drain_cnt;

    logic w_issue;
    logic w_last_col;
    logic w_last_row;
    logic w_drain_done;
    logic w_pending;
    logic w_acc_en;
    logic w_acc_clr;

    assign w_issue      = (r_state == RUN) && !bus.hold;
    assign w_last_col   = (r_col == CW'(N - 1));
    assign w_last_row   = (r_row == RW'(M - 1));
    // DRAIN needs its RD_LAT cycles and an empty line behind the output stage.
    assign w_drain_done = (r_drain_cnt == DW'(RD_LAT - 1)) && !w_pending;

    mv_dly #(.RD_LAT(RD_LAT)) u_dly (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_issue),
        .i_clr     (w_issue && (r_col == '0)),
        .o_en      (w_acc_en),
        .o_clr     (w_acc_clr),
        .o_pending (w_pending)
    );

    assign bus.acc_en  = w_acc_en;
    assign bus.acc_clr = w_acc_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.mat_rd_en   = 1'b0;
        bus.mat_rd_addr = '0;
        bus.vec_rd_addr = '0;
        bus.res_wr_en   = 1'b0;
        bus.res_wr_addr = '0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = RUN;
            end
            RUN: begin
                bus.busy      = 1'b1;
                bus.mat_rd_en = w_issue;
                if (w_issue) begin
                    bus.mat_rd_addr = r_mat_ptr;
                    bus.vec_rd_addr = r_vec_base + AW'(r_col);
                    if (w_last_col) w_next = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (w_drain_done) w_next = WRITE;
            end
            WRITE: begin
                bus.busy        = 1'b1;
                bus.res_wr_en   = 1'b1;
                bus.res_wr_addr = r_res_base + AW'(r_row);
                w_next          = w_last_row ? DONE : RUN;
            end
            DONE: begin
                bus.done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The matrix pointer simply runs +1 per read: rows are contiguous, so
    // row*N+col never needs a multiplier. Sums wrap naturally in AW bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mat_ptr   <= '0;
            r_vec_base  <= '0;
            r_res_base  <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mat_ptr  <= bus.mat_base;
                        r_vec_base <= bus.vec_base;
                        r_res_base <= bus.res_base;
                        r_col      <= '0;
                        r_row      <= '0;
                    end
                end
                RUN: begin
                    r_drain_cnt <= '0;
                    if (w_issue) begin
                        r_mat_ptr <= r_mat_ptr + AW'(1);
                        r_col     <= w_last_col ? '0 : r_col + CW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt != DW'(RD_LAT - 1)) begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end
                WRITE: begin
                    if (!w_last_row) r_row <= r_row + RW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mv_seq.sv
// tb/tb_mv_seq.sv - self-checking bench for mv_seq (three sizes run side by side)
module tb_mv_seq;
    import mv_pkg::*;

    localparam int WIN = 120;
    localparam int ND  = 3;
    localparam int M0 = 4, N0 = 4, L0 = 1;
    localparam int M1 = 3, N1 = 5, L1 = 3;
    localparam int M2 = 1, N2 = 1, L2 = 2;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [4:0] maddr;
        logic [4:0] vaddr;
        logic       acc_en;
        logic       acc_clr;
        logic       wr_en;
        logic [4:0] waddr;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mv_seq_if #(.AW(5)) if0 ();
    mv_seq_if #(.AW(5)) if1 ();
    mv_seq_if #(.AW(5)) if2 ();

    mv_seq #(.M(M0), .N(N0), .BRAM_DEPTH(32), .RD_LAT(L0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    mv_seq #(.M(M1), .N(N1), .BRAM_DEPTH(32), .RD_LAT(L1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mv_seq #(.M(M2), .N(N2), .BRAM_DEPTH(32), .RD_LAT(L2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    int checks = 0;
    int errors = 0;
    int dm[ND] = '{M0, M1, M2};
    int dn[ND] = '{N0, N1, N2};
    int dl[ND] = '{L0, L1, L2};

    bit   start_pat[WIN];
    bit   hold_pat[WIN];
    int   mb, vb, rb;
    obs_t exp_o[ND][WIN];
    obs_t act_o[ND][WIN];
    int   amem[32];
    int   xmem[32];
    int   resm[ND][32];
    int   acc[ND];
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic obs_t mko(input int busy, input int done, input int rd, input int ma,
                                 input int va, input int ae, input int ac, input int we, input int wa);
        obs_t o;
        o.busy = busy[0]; o.done = done[0]; o.rd_en = rd[0];
        o.maddr = 5'(ma); o.vaddr = 5'(va);
        o.acc_en = ae[0]; o.acc_clr = ac[0]; o.wr_en = we[0]; o.waddr = 5'(wa);
        return o;
    endfunction

    // Addresses and acc_clr only carry meaning alongside their strobe.
    function automatic obs_t get_obs(input int d, input bit mask);
        obs_t o;
        case (d)
            0: o = mko(if0.busy, if0.done, if0.mat_rd_en, if0.mat_rd_addr, if0.vec_rd_addr,
                       if0.acc_en, if0.acc_clr, if0.res_wr_en, if0.res_wr_addr);
            1: o = mko(if1.busy, if1.done, if1.mat_rd_en, if1.mat_rd_addr, if1.vec_rd_addr,
                       if1.acc_en, if1.acc_clr, if1.res_wr_en, if1.res_wr_addr);
            default: o = mko(if2.busy, if2.done, if2.mat_rd_en, if2.mat_rd_addr, if2.vec_rd_addr,
                             if2.acc_en, if2.acc_clr, if2.res_wr_en, if2.res_wr_addr);
        endcase
        if (mask) begin
            if (!o.rd_en) begin o.maddr = '0; o.vaddr = '0; end
            if (!o.acc_en) o.acc_clr = 1'b0;
            if (!o.wr_en) o.waddr = '0;
        end
        return o;
    endfunction

    task automatic drive(input logic s, input logic h);
        if0.start = s; if1.start = s; if2.start = s;
        if0.hold  = h; if1.hold  = h; if2.hold  = h;
    endtask

    task automatic set_bases();
        if0.mat_base = 5'(mb); if1.mat_base = 5'(mb); if2.mat_base = 5'(mb);
        if0.vec_base = 5'(vb); if1.vec_base = 5'(vb); if2.vec_base = 5'(vb);
        if0.res_base = 5'(rb); if1.res_base = 5'(rb); if2.res_base = 5'(rb);
    endtask

    task automatic clr_pats();
        for (int c = 0; c < WIN; c++) begin
            start_pat[c] = 1'b0;
            hold_pat[c]  = 1'b0;
        end
    endtask

    // Reference: walk the read schedule as the behaviour describes it. Each
    // accepted start issues M*N reads in row-major order, skipping held
    // cycles, then RD_LAT drain cycles and one write per row, then done.
    task automatic gen_exp(input int d);
        int m, n, rl, t, free;
        m = dm[d]; n = dn[d]; rl = dl[d];
        for (int c = 0; c < WIN; c++) exp_o[d][c] = '0;
        free = 0;
        for (int c = 0; c < WIN; c++) begin
            if (start_pat[c] && c >= free) begin
                t = c + 1;
                for (int r = 0; r < m; r++) begin
                    for (int k = 0; k < n; k++) begin
                        while (t < WIN && hold_pat[t]) t++;
                        if (t < WIN) begin
                            exp_o[d][t].rd_en = 1'b1;
                            exp_o[d][t].maddr = 5'((mb + r * n + k) % 32);
                            exp_o[d][t].vaddr = 5'((vb + k) % 32);
                        end
                        if (t + rl < WIN) begin
                            exp_o[d][t+rl].acc_en  = 1'b1;
                            exp_o[d][t+rl].acc_clr = (k == 0);
                        end
                        t++;
                    end
                    t += rl;
                    if (t < WIN) begin
                        exp_o[d][t].wr_en = 1'b1;
                        exp_o[d][t].waddr = 5'((rb + r) % 32);
                    end
                    t++;
                end
                for (int b = c + 1; b < t && b < WIN; b++) exp_o[d][b].busy = 1'b1;
                if (t < WIN) exp_o[d][t].done = 1'b1;
                free = t + 1;
            end
        end
    endtask

    // BRAM+MAC model: data at the MAC in cycle c comes from the read issued RD_LAT earlier.
    task automatic mac_step(input int d, input int c);
        obs_t o, s;
        int p;
        o = act_o[d][c];
        if (o.wr_en) resm[d][o.waddr] = acc[d];
        if (o.acc_en && c >= dl[d]) begin
            s = act_o[d][c - dl[d]];
            p = amem[s.maddr] * xmem[s.vaddr];
            acc[d] = o.acc_clr ? p : acc[d] + p;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) chk($sformatf("reset_state_d%0d", d), 64'(get_obs(d, 1'b0)), 64'(0));
        rst = 1'b1;
    endtask

    task automatic run_scen(input string tag);
        int g;
        for (int d = 0; d < ND; d++) begin
            gen_exp(d);
            acc[d] = 0;
            for (int a = 0; a < 32; a++) resm[d][a] = -1;
        end
        set_bases();
        for (int c = 0; c < WIN; c++) begin
            drive(start_pat[c], hold_pat[c]);
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                act_o[d][c] = get_obs(d, 1'b1);
                chk($sformatf("%s_d%0d_c%0d", tag, d, c), 64'(act_o[d][c]), 64'(exp_o[d][c]));
                mac_step(d, c);
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0);
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < dm[d]; r++) begin
                g = 0;
                for (int k = 0; k < dn[d]; k++)
                    g += amem[(mb + r * dn[d] + k) % 32] * xmem[(vb + k) % 32];
                chk($sformatf("%s_mac_d%0d_r%0d", tag, d, r), 64'(resm[d][(rb + r) % 32]), 64'(g));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            amem[a] = int'($urandom_range(0, 15));
            xmem[a] = int'($urandom_range(0, 15));
        end
        tbl[0]  = '{0,  mko(0, 0, 0, 0,  0, 0, 0, 0, 0)};
        tbl[1]  = '{1,  mko(1, 0, 1, 0,  0, 0, 0, 0, 0)};
        tbl[2]  = '{2,  mko(1, 0, 1, 1,  1, 1, 1, 0, 0)};
        tbl[3]  = '{5,  mko(1, 0, 0, 0,  0, 1, 0, 0, 0)};
        tbl[4]  = '{6,  mko(1, 0, 0, 0,  0, 0, 0, 1, 0)};
        tbl[5]  = '{7,  mko(1, 0, 1, 4,  0, 0, 0, 0, 0)};
        tbl[6]  = '{8,  mko(1, 0, 1, 5,  1, 1, 1, 0, 0)};
        tbl[7]  = '{12, mko(1, 0, 0, 0,  0, 0, 0, 1, 1)};
        tbl[8]  = '{18, mko(1, 0, 0, 0,  0, 0, 0, 1, 2)};
        tbl[9]  = '{22, mko(1, 0, 1, 15, 3, 1, 0, 0, 0)};
        tbl[10] = '{24, mko(1, 0, 0, 0,  0, 0, 0, 1, 3)};
        tbl[11] = '{25, mko(0, 1, 0, 0,  0, 0, 0, 0, 0)};
        tbl[12] = '{26, mko(0, 0, 0, 0,  0, 0, 0, 0, 0)};

        mb = 0; vb = 0; rb = 0;
        set_bases();

        // Basic run, bases 0, start at cycle 0.
        do_reset();
        clr_pats();
        start_pat[0] = 1'b1;
        run_scen("basic");
        for (int i = 0; i < 13; i++)
            chk($sformatf("tbl_c%0d", tbl[i].cyc), 64'(act_o[0][tbl[i].cyc]), 64'(tbl[i].exp));

        // Two-cycle hold at row 1, col 2 of the 4x4 instance.
        do_reset();
        clr_pats();
        start_pat[0] = 1'b1;
        hold_pat[9] = 1'b1;
        hold_pat[10] = 1'b1;
        run_scen("hold");
        chk("hold_no_rd_c10", 64'(act_o[0][10].rd_en), 64'(0));
        chk("hold_addr_c11", 64'(act_o[0][11].maddr), 64'(6));
        chk("hold_bubble_c11", 64'(act_o[0][11].acc_en), 64'(0));
        chk("hold_acc_c12", 64'(act_o[0][12].acc_en), 64'(1));
        chk("hold_write_c14", 64'({act_o[0][14].wr_en, act_o[0][14].waddr}), 64'({1'b1, 5'd1}));

        // Address wrap and ignored starts (during RUN and during DONE).
        do_reset();
        clr_pats();
        mb = 30; vb = 31; rb = 31;
        start_pat[0] = 1'b1;
        start_pat[3] = 1'b1;
        start_pat[25] = 1'b1;
        run_scen("wrap");
        chk("wrap_m_c2", 64'(act_o[0][2].maddr), 64'(31));
        chk("wrap_m_c3", 64'(act_o[0][3].maddr), 64'(0));
        chk("wrap_v_c2", 64'(act_o[0][2].vaddr), 64'(0));
        chk("wrap_w_c24", 64'(act_o[0][24].waddr), 64'(2));
        chk("no_rerun_c27", 64'({act_o[0][27].busy, act_o[0][27].rd_en}), 64'(0));

        // Randomised bases, holds and stray starts.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            clr_pats();
            mb = int'($urandom_range(0, 31));
            vb = int'($urandom_range(0, 31));
            rb = int'($urandom_range(0, 31));
            start_pat[0] = 1'b1;
            for (int c = 0; c < WIN; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
            start_pat[$urandom_range(1, 60)] = 1'b1;
            start_pat[$urandom_range(1, 60)] = 1'b1;
            run_scen($sformatf("rnd%0d", it));
        end

        // Reset during row 2 RUN of the 4x4 instance, then a fresh run.
        do_reset();
        mb = 5; vb = 9; rb = 2;
        set_bases();
        drive(1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0);
        repeat (13) @(posedge clk);
        #2;
        chk("pre_reset_rd_en", 64'(if0.mat_rd_en), 64'(1));
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) chk($sformatf("async_reset_d%0d", d), 64'(get_obs(d, 1'b0)), 64'(0));
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("held_reset_d%0d", d), 64'(get_obs(d, 1'b0)), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr_pats();
        mb = 17; vb = 4; rb = 20;
        start_pat[0] = 1'b1;
        run_scen("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mv_seq.md
Name: mv_seq

Overview:
- Top-level sequencer for a dense matrix-vector multiply, y = A·x, with A of size M×N.
- Streams matrix row elements and vector elements out of the BRAMs and drives accumulator clear/enable on the MAC datapath.
- Writes one result word per row back to BRAM.
- Sits between the host start/done interface and the BRAM/MAC datapath, and replaces per-row manual sequencing of the existing read/write address counters.

Parameters:
- M, 4, number of matrix rows (result elements); M >= 1.
- N, 4, number of columns (vector length); N >= 1.
- BRAM_DEPTH, 32, words per BRAM; all address ports are $clog2(BRAM_DEPTH) bits wide (AW).
- RD_LAT, 1, BRAM read latency in cycles from rd_en to data valid at the MAC input; RD_LAT >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low: asserted when 0, released synchronously to clk by the integrator.
- start  in  1  one-cycle request; sampled only in IDLE.
- hold  in  1  stall request; while high in RUN, no read is issued.
- mat_base  in  AW  matrix base address; latched on accepted start.
- vec_base  in  AW  vector base address; latched on accepted start.
- res_base  in  AW  result base address; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the final WRITE cycle.
- done  out  1  one-cycle pulse when all M results are written.
- mat_rd_en  out  1  matrix BRAM read strobe.
- mat_rd_addr  out  AW  matrix read address.
- vec_rd_addr  out  AW  vector read address; valid with mat_rd_en.
- acc_en  out  1  MAC accumulate enable; equals mat_rd_en delayed RD_LAT cycles.
- acc_clr  out  1  qualifies acc_en: load the product instead of adding it (first column of a row).
- res_wr_en  out  1  result write strobe.
- res_wr_addr  out  AW  result write address.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including the delay line; row and column counters 0; latched bases 0.
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 latches the three bases, clears row and col, and moves to RUN next cycle.
  - start in any other state is ignored; it is neither queued nor an error.
- RUN:
  - With hold=0: mat_rd_en=1, mat_rd_addr=mat_base+row*N+col, vec_rd_addr=vec_base+col, then col increments.
  - With hold=1: mat_rd_en=0 and col holds.
  - On the issue cycle where col==N-1, move to DRAIN and reset col to 0.
- Address generation: keep a running matrix pointer (+1 per read), not a multiplier. All address sums wrap modulo BRAM_DEPTH.
- Delay line: acc_en and acc_clr are mat_rd_en and (mat_rd_en && col==0) delayed exactly RD_LAT cycles. The line shifts every cycle regardless of hold, so a hold produces bubbles rather than a stall.
- DRAIN:
  - Lasts exactly RD_LAT cycles, then moves to WRITE.
  - The last acc_en of a row falls in the last DRAIN cycle when no hold occurred in the final RD_LAT issue slots.
  - If the delay line still holds a pending acc_en, extend DRAIN until the line is empty.
- WRITE: one cycle; res_wr_en=1, res_wr_addr=res_base+row.
  - If row==M-1, go to DONE.
  - Otherwise row increments and the FSM returns to RUN.
- DONE: one cycle; done=1, busy=0; next state IDLE.
- A start arriving in the DONE cycle is ignored. start in the following IDLE cycle is accepted.
- Latency with no hold: WRITE of row r ends at cycle (r+1)*(N+RD_LAT+1) after the start cycle; done is asserted in cycle M*(N+RD_LAT+1)+1.
- Reset mid-operation: immediate return to IDLE, all strobes drop in the same cycle, and no partial result is written afterwards.
- hold is a don't-care outside RUN.

Decomposition:
- Package mv_pkg holds:
  - state enum typedef (IDLE, RUN, DRAIN, WRITE, DONE);
  - localparam helper for the address width;
  - shared default constants for M, N, RD_LAT.
- One sub-module, mv_dly: parameterised RD_LAT-deep shift register, width 2 ({acc_clr, acc_en}), with asynchronous active-low reset. It also exposes an any-pending flag for the DRAIN extension.

Test Plan:
- Basic run, M=4, N=4, RD_LAT=1, all bases 0, start at cycle 0:
  - mat_rd_addr 0..15 and vec_rd_addr 0..3 repeating;
  - res_wr_en at cycles 6, 12, 18, 24 with res_wr_addr 0..3;
  - done at cycle 25 only; busy high for cycles 1-24.
- acc timing: acc_en trails mat_rd_en by exactly 1 cycle (RD_LAT=1) and by 3 cycles with RD_LAT=3. acc_clr is high only with the first acc_en of each row, and the model's MAC outputs match the golden A·x.
- Hold: assert hold for 2 cycles at col 2 of row 1. Row 1 WRITE slips by 2 cycles, addresses show no skip or duplicate, acc_en shows a 2-cycle bubble, and results are unchanged.
- Wrap and ignore: set mat_base=30 with BRAM_DEPTH=32 and confirm reads run 30, 31, 0, 1, .... Pulse start during RUN and during DONE: no second run occurs.
- Reset mid-run: drive rst=0 during row 2 RUN. All outputs are 0 asynchronously, and a start after release restarts from row 0 with newly latched bases.
- Edge sizes: M=1, N=1 gives RUN 1 cycle, DRAIN RD_LAT cycles, one WRITE to res_base, then done.
